// File: rtl/pmod_spi_rx.sv
// SPI mode-0 responder: deserialises csn/mosi/sck frames into number; optional BCD check via PMOD_SPI_RX_BCD_CHECK_EN.
// Latency: csn rise at pin -> valid/frame_err after SYNC_STAGES+2 clk; no backpressure, valid is a one-cycle strobe.
module pmod_spi_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csn,
    input  logic             mosi,
    input  logic             sck,
    output logic [WIDTH-1:0] number,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic             bcd_err
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
    logic                   csn_s, sck_s, mosi_s;
    logic                   csn_d, sck_d;
    logic                   csn_fall, csn_rise, sck_rise;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       shreg;
    logic                   frame_good;

    // Synchronisers reset to 0 so a csn held high through reset reads as a rise, never a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync  <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            csn_d     <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            csn_d     <= csn_s;
            sck_d     <= sck_s;
        end
    end

    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csn_fall = csn_d & ~csn_s;
    assign csn_rise = ~csn_d & csn_s;
    assign sck_rise = ~sck_d & sck_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = SHIFT;
            SHIFT:   if (csn_rise) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state == SHIFT);
    assign frame_good = (state == DONE) && (cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shreg     <= '0;
            number    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                SHIFT: begin
                    // A csn rise in the same cycle closes the frame before this sck edge counts.
                    if (sck_rise && !csn_rise) begin
                        shreg <= {shreg[WIDTH-2:0], mosi_s};
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (frame_good) begin
                        number <= shreg;
                        valid  <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef PMOD_SPI_RX_BCD_CHECK_EN
    function automatic logic has_bad_nibble(input logic [WIDTH-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_err <= 1'b0;
        end else if (frame_good && has_bad_nibble(shreg)) begin
            bcd_err <= 1'b1;
        end
    end
`else
    assign bcd_err = 1'b0;
`endif

endmodule
